// File: rtl/soc_sram_arbiter_if.sv
// Bus bundle between the SERV instruction/data buses, the SRAM arbiter and the SRAM macro.
// The arbiter takes the slave modport; the bus masters and the SRAM model take the master modport.
interface soc_sram_arbiter_if #(
  parameter int AW = 10
);
  logic [31:0]   i_ibus_adr;
  logic          i_ibus_cyc;
  logic [31:0]   o_ibus_rdt;
  logic          o_ibus_ack;

  logic [31:0]   i_dbus_adr;
  logic [31:0]   i_dbus_dat;
  logic [3:0]    i_dbus_sel;
  logic          i_dbus_we;
  logic          i_dbus_cyc;
  logic [31:0]   o_dbus_rdt;
  logic          o_dbus_ack;

  logic [AW-1:0] o_sram_addr;
  logic [31:0]   o_sram_wdata;
  logic [3:0]    o_sram_sel;
  logic          o_sram_we;
  logic          o_sram_cs;
  logic [31:0]   i_sram_rdata;
  logic          i_sram_ack;

  logic          o_timeout;

  modport slave (
    input  i_ibus_adr, i_ibus_cyc,
    output o_ibus_rdt, o_ibus_ack,
    input  i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we, i_dbus_cyc,
    output o_dbus_rdt, o_dbus_ack,
    output o_sram_addr, o_sram_wdata, o_sram_sel, o_sram_we, o_sram_cs,
    input  i_sram_rdata, i_sram_ack,
    output o_timeout
  );

  modport master (
    output i_ibus_adr, i_ibus_cyc,
    input  o_ibus_rdt, o_ibus_ack,
    output i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we, i_dbus_cyc,
    input  o_dbus_rdt, o_dbus_ack,
    input  o_sram_addr, o_sram_wdata, o_sram_sel, o_sram_we, o_sram_cs,
    output i_sram_rdata, i_sram_ack,
    input  o_timeout
  );
endinterface

// File: rtl/soc_sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between the SERV ibus and dbus,
// with registered SRAM-side outputs and a per-transaction timeout watchdog.
//
// state | meaning
// IDLE  | no access in flight; grant decided here, SRAM outputs loaded on exit
// GNT_I | ibus owns the SRAM, waiting for i_sram_ack or timeout
// GNT_D | dbus owns the SRAM, waiting for i_sram_ack or timeout
module soc_sram_arbiter #(
  parameter int          AW       = 10,
  parameter int          TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic             clk,
  input  logic             i_rst_n,
  soc_sram_arbiter_if.slave bus
);
  localparam int             TW       = $clog2(TIMEOUT);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t        state, state_nxt;
  logic          last_gnt_d;
  logic [TW-1:0] timer;

  logic          cur_cyc;
  logic          tmo_hit;
  logic          fin;
  logic          abort;
  logic [31:0]   ack_rdt;

  logic          unused_adr_bits;
  assign unused_adr_bits = ^{bus.i_ibus_adr[31:AW+2], bus.i_ibus_adr[1:0],
                             bus.i_dbus_adr[31:AW+2], bus.i_dbus_adr[1:0]};

  always_comb begin
    state_nxt       = state;
    cur_cyc         = 1'b0;
    tmo_hit         = (timer == TMO_LAST);
    fin             = 1'b0;
    abort           = 1'b0;
    ack_rdt         = bus.i_sram_ack ? bus.i_sram_rdata : ERR_DATA;
    bus.o_ibus_ack  = 1'b0;
    bus.o_ibus_rdt  = 32'h0;
    bus.o_dbus_ack  = 1'b0;
    bus.o_dbus_rdt  = 32'h0;
    bus.o_timeout   = 1'b0;

    case (state)
      IDLE: begin
        if (bus.i_ibus_cyc && (!bus.i_dbus_cyc || last_gnt_d))
          state_nxt = GNT_I;
        else if (bus.i_dbus_cyc)
          state_nxt = GNT_D;
      end
      GNT_I: cur_cyc = bus.i_ibus_cyc;
      GNT_D: cur_cyc = bus.i_dbus_cyc;
      default: state_nxt = IDLE;
    endcase

    if (state != IDLE) begin
      // a master dropping cyc mid-access gets no ack, even if the SRAM answers now
      fin   = cur_cyc && (bus.i_sram_ack || tmo_hit);
      abort = !cur_cyc;
      if (fin || abort)
        state_nxt = IDLE;
      bus.o_timeout = fin && !bus.i_sram_ack;
    end

    if (fin && state == GNT_I) begin
      bus.o_ibus_ack = 1'b1;
      bus.o_ibus_rdt = ack_rdt;
    end
    if (fin && state == GNT_D) begin
      bus.o_dbus_ack = 1'b1;
      bus.o_dbus_rdt = ack_rdt;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      last_gnt_d <= 1'b1;
      timer      <= '0;
    end else begin
      state <= state_nxt;
      if (fin)
        last_gnt_d <= (state == GNT_D);
      if (state != IDLE && state_nxt != IDLE)
        timer <= timer + 1'b1;
      else
        timer <= '0;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_sram_addr  <= '0;
      bus.o_sram_wdata <= '0;
      bus.o_sram_sel   <= '0;
      bus.o_sram_we    <= 1'b0;
      bus.o_sram_cs    <= 1'b0;
    end else if (state == IDLE && state_nxt == GNT_I) begin
      bus.o_sram_addr  <= bus.i_ibus_adr[AW+1:2];
      bus.o_sram_wdata <= '0;
      bus.o_sram_sel   <= 4'hF;
      bus.o_sram_we    <= 1'b0;
      bus.o_sram_cs    <= 1'b1;
    end else if (state == IDLE && state_nxt == GNT_D) begin
      bus.o_sram_addr  <= bus.i_dbus_adr[AW+1:2];
      bus.o_sram_wdata <= bus.i_dbus_dat;
      bus.o_sram_sel   <= bus.i_dbus_sel;
      bus.o_sram_we    <= bus.i_dbus_we;
      bus.o_sram_cs    <= 1'b1;
    end else if (state != IDLE && state_nxt == IDLE) begin
      bus.o_sram_we    <= 1'b0;
      bus.o_sram_cs    <= 1'b0;
    end
  end
endmodule

// File: tb/tb_soc_sram_arbiter.sv
// Directed bench for soc_sram_arbiter: grant order, address translation, ack routing,
// timeout watchdog, cyc-drop abort and asynchronous reset mid-access.
module tb_soc_sram_arbiter;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic i_rst_n = 1'b0;
  int   vecs = 0;
  int   miscompares = 0;

  soc_sram_arbiter_if #(.AW(AW)) bif ();

  soc_sram_arbiter #(.AW(AW), .TIMEOUT(8), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .bus     (bif.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bif.i_ibus_adr   = '0;
    bif.i_ibus_cyc   = 1'b0;
    bif.i_dbus_adr   = '0;
    bif.i_dbus_dat   = '0;
    bif.i_dbus_sel   = '0;
    bif.i_dbus_we    = 1'b0;
    bif.i_dbus_cyc   = 1'b0;
    bif.i_sram_rdata = '0;
    bif.i_sram_ack   = 1'b0;

    // reset state
    #3;
    check("rst_cs",    32'(bif.o_sram_cs), 32'd0);
    check("rst_we",    32'(bif.o_sram_we), 32'd0);
    check("rst_addr",  32'(bif.o_sram_addr), 32'd0);
    check("rst_sel",   32'(bif.o_sram_sel), 32'd0);
    check("rst_wdata", bif.o_sram_wdata, 32'd0);
    check("rst_tmo",   32'(bif.o_timeout), 32'd0);
    #9 i_rst_n = 1'b1;
    step();

    // 1: ibus fetch, SRAM acks two cycles after cs rises
    bif.i_ibus_cyc = 1'b1;
    bif.i_ibus_adr = 32'h0000_0010;
    #1 check("t1_cs_latency", 32'(bif.o_sram_cs), 32'd0);
    step();
    check("t1_cs",   32'(bif.o_sram_cs), 32'd1);
    check("t1_addr", 32'(bif.o_sram_addr), 32'h4);
    check("t1_we",   32'(bif.o_sram_we), 32'd0);
    check("t1_sel",  32'(bif.o_sram_sel), 32'hF);
    check("t1_noack0", 32'(bif.o_ibus_ack), 32'd0);
    step();
    check("t1_noack1", 32'(bif.o_ibus_ack), 32'd0);
    step();
    bif.i_sram_ack   = 1'b1;
    bif.i_sram_rdata = 32'h1234_5678;
    #1;
    check("t1_iack",  32'(bif.o_ibus_ack), 32'd1);
    check("t1_irdt",  bif.o_ibus_rdt, 32'h1234_5678);
    check("t1_dack",  32'(bif.o_dbus_ack), 32'd0);
    check("t1_drdt",  bif.o_dbus_rdt, 32'd0);
    check("t1_tmo",   32'(bif.o_timeout), 32'd0);
    step();
    bif.i_sram_ack = 1'b0;
    bif.i_ibus_cyc = 1'b0;
    check("t1_cs_off", 32'(bif.o_sram_cs), 32'd0);
    check("t1_iack_off", 32'(bif.o_ibus_ack), 32'd0);
    check("t1_irdt_off", bif.o_ibus_rdt, 32'd0);

    // 2: dbus write
    bif.i_dbus_cyc = 1'b1;
    bif.i_dbus_adr = 32'h0000_0104;
    bif.i_dbus_dat = 32'hCAFE_F00D;
    bif.i_dbus_sel = 4'b0011;
    bif.i_dbus_we  = 1'b1;
    step();
    check("t2_addr",  32'(bif.o_sram_addr), 32'h41);
    check("t2_wdata", bif.o_sram_wdata, 32'hCAFE_F00D);
    check("t2_sel",   32'(bif.o_sram_sel), 32'h3);
    check("t2_we",    32'(bif.o_sram_we), 32'd1);
    bif.i_sram_ack   = 1'b1;
    bif.i_sram_rdata = 32'h0;
    #1;
    check("t2_dack", 32'(bif.o_dbus_ack), 32'd1);
    check("t2_iack", 32'(bif.o_ibus_ack), 32'd0);
    step();
    bif.i_sram_ack = 1'b0;
    bif.i_dbus_cyc = 1'b0;
    bif.i_dbus_we  = 1'b0;
    check("t2_we_off", 32'(bif.o_sram_we), 32'd0);
    check("t2_cs_off", 32'(bif.o_sram_cs), 32'd0);

    // 3: both masters continuously requesting -> I, D, I, D with one idle cycle between
    bif.i_ibus_adr = 32'h0000_0020;
    bif.i_dbus_adr = 32'h0000_0030;
    bif.i_dbus_sel = 4'hF;
    bif.i_ibus_cyc = 1'b1;
    bif.i_dbus_cyc = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic        exp_i;
      logic [31:0] exp_addr;
      exp_i    = (k % 2 == 0);
      exp_addr = exp_i ? 32'h8 : 32'hC;
      step();
      check("t3_cs",   32'(bif.o_sram_cs), 32'd1);
      check("t3_addr", 32'(bif.o_sram_addr), exp_addr);
      bif.i_sram_ack   = 1'b1;
      bif.i_sram_rdata = 32'h100 + k;
      #1;
      check("t3_iack", 32'(bif.o_ibus_ack), 32'(exp_i));
      check("t3_dack", 32'(bif.o_dbus_ack), 32'(!exp_i));
      check("t3_rdt",  exp_i ? bif.o_ibus_rdt : bif.o_dbus_rdt, 32'h100 + k);
      step();
      bif.i_sram_ack = 1'b0;
      check("t3_idle_cs", 32'(bif.o_sram_cs), 32'd0);
      if (k == 3) begin
        bif.i_ibus_cyc = 1'b0;
        bif.i_dbus_cyc = 1'b0;
      end
    end

    // 4: dbus read never acked -> forced error ack in the 8th grant cycle, then ibus
    bif.i_dbus_adr = 32'h0000_0040;
    bif.i_dbus_cyc = 1'b1;
    step();
    check("t4_cs",   32'(bif.o_sram_cs), 32'd1);
    check("t4_addr", 32'(bif.o_sram_addr), 32'h10);
    bif.i_ibus_adr = 32'h0000_0050;
    bif.i_ibus_cyc = 1'b1;
    for (int k = 0; k < 7; k++) begin
      #1;
      check("t4_early_ack", 32'(bif.o_dbus_ack), 32'd0);
      check("t4_early_tmo", 32'(bif.o_timeout), 32'd0);
      step();
    end
    check("t4_dack", 32'(bif.o_dbus_ack), 32'd1);
    check("t4_tmo",  32'(bif.o_timeout), 32'd1);
    check("t4_rdt",  bif.o_dbus_rdt, 32'hDEAD_BEEF);
    check("t4_iack", 32'(bif.o_ibus_ack), 32'd0);
    step();
    bif.i_dbus_cyc = 1'b0;
    check("t4_idle_cs", 32'(bif.o_sram_cs), 32'd0);
    check("t4_tmo_off", 32'(bif.o_timeout), 32'd0);
    step();
    check("t4_next_addr", 32'(bif.o_sram_addr), 32'h14);
    check("t4_next_sel",  32'(bif.o_sram_sel), 32'hF);
    bif.i_sram_ack   = 1'b1;
    bif.i_sram_rdata = 32'h1111_1111;
    #1 check("t4_next_iack", 32'(bif.o_ibus_ack), 32'd1);
    step();
    bif.i_sram_ack = 1'b0;
    bif.i_ibus_cyc = 1'b0;

    // 5: ack arrives in the same cycle the watchdog would fire
    bif.i_dbus_adr = 32'h0000_0044;
    bif.i_dbus_cyc = 1'b1;
    step();
    check("t5_addr", 32'(bif.o_sram_addr), 32'h11);
    for (int k = 0; k < 7; k++) step();
    bif.i_sram_ack   = 1'b1;
    bif.i_sram_rdata = 32'hA5A5_5A5A;
    #1;
    check("t5_dack", 32'(bif.o_dbus_ack), 32'd1);
    check("t5_rdt",  bif.o_dbus_rdt, 32'hA5A5_5A5A);
    check("t5_tmo",  32'(bif.o_timeout), 32'd0);
    step();
    bif.i_sram_ack = 1'b0;
    bif.i_dbus_cyc = 1'b0;

    // ibus drops cyc mid-access: no ack, back to idle, last grant stays dbus
    bif.i_ibus_adr = 32'h0000_0060;
    bif.i_ibus_cyc = 1'b1;
    step();
    check("ab_addr", 32'(bif.o_sram_addr), 32'h18);
    bif.i_ibus_cyc = 1'b0;
    bif.i_sram_ack = 1'b1;
    #1;
    check("ab_iack", 32'(bif.o_ibus_ack), 32'd0);
    check("ab_irdt", bif.o_ibus_rdt, 32'd0);
    step();
    bif.i_sram_ack = 1'b0;
    check("ab_cs", 32'(bif.o_sram_cs), 32'd0);
    bif.i_ibus_adr = 32'h0000_0070;
    bif.i_dbus_adr = 32'h0000_0080;
    bif.i_dbus_dat = 32'h0BAD_F00D;
    bif.i_dbus_sel = 4'b1100;
    bif.i_dbus_we  = 1'b1;
    bif.i_ibus_cyc = 1'b1;
    bif.i_dbus_cyc = 1'b1;
    step();
    check("ab_regrant_addr", 32'(bif.o_sram_addr), 32'h1C);
    bif.i_sram_ack = 1'b1;
    #1 check("ab_regrant_iack", 32'(bif.o_ibus_ack), 32'd1);
    step();
    bif.i_sram_ack = 1'b0;
    bif.i_ibus_cyc = 1'b0;
    step();

    // 6: async reset while dbus write is granted
    check("t6_cs",   32'(bif.o_sram_cs), 32'd1);
    check("t6_we",   32'(bif.o_sram_we), 32'd1);
    check("t6_sel",  32'(bif.o_sram_sel), 32'hC);
    check("t6_addr", 32'(bif.o_sram_addr), 32'h20);
    bif.i_ibus_adr = 32'h0000_0090;
    bif.i_ibus_cyc = 1'b1;
    bif.i_sram_ack = 1'b1;
    #1 check("t6_dack_pre", 32'(bif.o_dbus_ack), 32'd1);
    i_rst_n = 1'b0;
    #1;
    check("t6_rst_cs",   32'(bif.o_sram_cs), 32'd0);
    check("t6_rst_we",   32'(bif.o_sram_we), 32'd0);
    check("t6_rst_dack", 32'(bif.o_dbus_ack), 32'd0);
    check("t6_rst_iack", 32'(bif.o_ibus_ack), 32'd0);
    bif.i_sram_ack = 1'b0;
    @(negedge clk);
    i_rst_n = 1'b1;
    step();
    check("t6_first_addr", 32'(bif.o_sram_addr), 32'h24);
    check("t6_first_we",   32'(bif.o_sram_we), 32'd0);
    bif.i_sram_ack   = 1'b1;
    bif.i_sram_rdata = 32'h7777_0000;
    #1;
    check("t6_first_iack", 32'(bif.o_ibus_ack), 32'd1);
    check("t6_first_dack", 32'(bif.o_dbus_ack), 32'd0);
    step();
    bif.i_sram_ack = 1'b0;
    bif.i_ibus_cyc = 1'b0;
    bif.i_dbus_cyc = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end
endmodule
